// File: rtl/alu_op_sequencer_if.sv
// Command and result handshake bundle for alu_op_sequencer.
// Master is the upstream issuer and downstream consumer.
interface alu_op_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic [3:0] out_flags;

  modport master (
    output in_valid, in_op, in_a, in_b,
    output out_ready,
    input  in_ready,
    input  out_valid, out_sum, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b,
    input  out_ready,
    output in_ready,
    output out_valid, out_sum, out_flags
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Control stage around an external 8-bit add/sub datapath:
// command intake, NZCV flag register and result FIFO.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_op_sequencer_if.slave        io,
  output logic [7:0]               add_a,
  output logic [7:0]               add_b,
  output logic                     add_cin,
  output logic                     add_sub,
  input  logic [7:0]               add_sum,
  input  logic                     add_cout,
  output logic [3:0]               flags,
  output logic                     err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_CMP  = 3'b100;
  localparam logic [2:0] OP_CLRC = 3'b101;
  localparam logic [2:0] OP_SETC = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [7:0]    add_a_q, add_a_d;
  logic [7:0]    add_b_q, add_b_d;
  logic          add_cin_q, add_cin_d;
  logic          add_sub_q, add_sub_d;
  logic [3:0]    flags_q, flags_d;
  logic          err_q, err_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [11:0]   mem_q [FIFO_DEPTH];

  logic          accept;
  logic          push;
  logic          pop;
  logic [7:0]    b_eff;
  logic [3:0]    alu_flags;
  logic [11:0]   head;

  assign io.in_ready = (state_q == IDLE)
                    && (count_q < CW'(FIFO_DEPTH));
  assign accept = io.in_valid && io.in_ready;
  assign pop    = io.out_valid && io.out_ready;

  // V is judged on the operand the adder really adds.
  assign b_eff = add_sub_q ? ~add_b_q : add_b_q;
  assign alu_flags = {
    add_sum[7],
    add_sum == 8'h00,
    add_cout,
    (add_a_q[7] == b_eff[7]) && (add_sum[7] != add_a_q[7])
  };

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;
    add_sub_d = add_sub_q;
    flags_d   = flags_q;
    err_d     = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          op_d    = io.in_op;
          err_d   = io.in_op == OP_RSV;
          unique case (1'b1)
            (io.in_op == OP_ADD): begin
              add_a_d   = io.in_a;
              add_b_d   = io.in_b;
              add_cin_d = 1'b0;
              add_sub_d = 1'b0;
            end
            (io.in_op == OP_ADC): begin
              add_a_d   = io.in_a;
              add_b_d   = io.in_b;
              add_cin_d = flags_q[1];
              add_sub_d = 1'b0;
            end
            (io.in_op == OP_SUB),
            (io.in_op == OP_CMP): begin
              add_a_d   = io.in_a;
              add_b_d   = io.in_b;
              add_cin_d = 1'b0;
              add_sub_d = 1'b1;
            end
            // Adder ORs cin with sub, so borrow-in needs sub low.
            (io.in_op == OP_SBC): begin
              add_a_d   = io.in_a;
              add_b_d   = ~io.in_b;
              add_cin_d = flags_q[1];
              add_sub_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      EXEC: begin
        state_d = IDLE;
        unique case (1'b1)
          (op_q == OP_CLRC): flags_d[1] = 1'b0;
          (op_q == OP_SETC): flags_d[1] = 1'b1;
          (op_q == OP_RSV):  ;
          default: begin
            flags_d = alu_flags;
            push    = op_q != OP_CMP;
          end
        endcase
      end
    endcase
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      add_sub_q <= 1'b0;
      flags_q   <= '0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
      add_sub_q <= add_sub_d;
      flags_q   <= flags_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      if (push) mem_q[wr_ptr_q] <= {add_sum, alu_flags};
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign io.out_valid = count_q != '0;
  assign io.out_sum   = io.out_valid ? head[11:4] : 8'h00;
  assign io.out_flags = io.out_valid ? head[3:0]  : 4'h0;

  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_cin = add_cin_q;
  assign add_sub = add_sub_q;
  assign flags   = flags_q;
  assign err     = err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and random bench for alu_op_sequencer with an
// arithmetic reference model and an adder model.
module tb_alu_op_sequencer;
  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] ADC  = 3'd1;
  localparam logic [2:0] SUB  = 3'd2;
  localparam logic [2:0] SBC  = 3'd3;
  localparam logic [2:0] CMP  = 3'd4;
  localparam logic [2:0] CLRC = 3'd5;
  localparam logic [2:0] SETC = 3'd6;
  localparam logic [2:0] RSV  = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if bus ();

  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin, add_sub, add_cout;
  logic [3:0] flags;
  logic       err;

  alu_op_sequencer #(.FIFO_DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (bus.slave),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sub  (add_sub),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .flags    (flags),
    .err      (err)
  );

  // The datapath: sub inverts b and forces carry-in.
  logic [7:0] b_in;
  assign b_in = add_sub ? ~add_b : add_b;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, b_in}
                             + {8'h00, add_cin | add_sub};

  int total = 0;
  int bad   = 0;
  logic [3:0]  mflags;
  logic [11:0] exp_q[$];

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags from true integer arithmetic; C=1 means no borrow.
  function automatic void model(input logic [2:0] op,
                                input logic [7:0] a,
                                input logic [7:0] b);
    int ua, ub, sa, sb, c, u, s;
    logic nc;
    logic [7:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c  = int'(mflags[1]);
    case (op)
      ADD: begin u = ua + ub;     s = sa + sb;     nc = u > 255; end
      ADC: begin u = ua + ub + c; s = sa + sb + c; nc = u > 255; end
      SUB, CMP: begin
        u = ua - ub; s = sa - sb; nc = u >= 0;
      end
      SBC: begin
        u = ua - ub - (1 - c); s = sa - sb - (1 - c); nc = u >= 0;
      end
      CLRC: begin mflags[1] = 1'b0; return; end
      SETC: begin mflags[1] = 1'b1; return; end
      default: return;
    endcase
    r = u[7:0];
    mflags = {r[7], r == 8'h00, nc, (s > 127) || (s < -128)};
    if (op != CMP) exp_q.push_back({r, mflags});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    logic [11:0] e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
    chk({tag, "_sum"}, 16'(bus.out_sum), 16'(e[11:4]));
    chk({tag, "_flags"}, 16'(bus.out_flags), 16'(e[3:0]));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input bit do_pop);
    bit acc;
    logic [7:0]  nb;
    logic [11:0] h;
    logic        cin_e;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("accept", 16'(acc), 16'd1);
    if (!acc) return;
    chk("exec_in_ready", 16'(bus.in_ready), 16'd0);
    chk("exec_err", 16'(err), 16'(op == RSV));
    chk("exec_out_valid", 16'(bus.out_valid),
        16'(exp_q.size() != 0));
    if (op inside {ADD, ADC, SUB, SBC, CMP}) begin
      nb = (op == SBC) ? ~b : b;
      cin_e = (op == ADC || op == SBC) ? mflags[1] : 1'b0;
      chk("drv_a", 16'(add_a), 16'(a));
      chk("drv_b", 16'(add_b), 16'(nb));
      chk("drv_cin", 16'(add_cin), 16'(cin_e));
      chk("drv_sub", 16'(add_sub), 16'(op == SUB || op == CMP));
    end
    model(op, a, b);
    tick();
    chk("flags", 16'(flags), 16'(mflags));
    chk("err_clear", 16'(err), 16'd0);
    chk("out_valid", 16'(bus.out_valid), 16'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("head_sum", 16'(bus.out_sum), 16'(h[11:4]));
    end
    if (do_pop) pop_check("pop");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [11:0] h;
    logic [2:0]  rop;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.out_ready = 1'b0;
    mflags = 4'h0;

    #12;
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_out_sum", 16'(bus.out_sum), 16'd0);
    chk("rst_out_flags", 16'(bus.out_flags), 16'd0);
    chk("rst_flags", 16'(flags), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_add", {add_a, add_b}, 16'd0);
    chk("rst_cin_sub", 16'({add_cin, add_sub}), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 16'(bus.in_ready), 16'd1);

    do_op(ADD, 8'h7F, 8'h01, 1'b1);
    chk("add7f_flags", 16'(flags), 16'h9);
    do_op(SUB, 8'h05, 8'h05, 1'b1);
    chk("sub55_flags", 16'(flags), 16'h6);
    do_op(CMP, 8'h03, 8'h04, 1'b1);
    chk("cmp_flags", 16'(flags), 16'h8);
    chk("cmp_no_push", 16'(bus.out_valid), 16'd0);

    do_op(ADD, 8'hFF, 8'h01, 1'b0);
    do_op(ADC, 8'h00, 8'h00, 1'b0);
    pop_check("chk16_lo");
    pop_check("chk16_hi");
    chk("adc_flags", 16'(flags), 16'h0);

    do_op(SUB, 8'h00, 8'h01, 1'b0);
    do_op(SBC, 8'h00, 8'h00, 1'b0);
    pop_check("brw_lo");
    pop_check("brw_hi");
    chk("sbc_flags", 16'(flags), 16'h8);
    do_op(SETC, 8'h00, 8'h00, 1'b1);
    do_op(SBC, 8'h00, 8'h00, 1'b1);
    chk("setc_sbc_flags", 16'(flags), 16'h6);

    do_op(ADD, 8'h11, 8'h22, 1'b0);
    do_op(ADD, 8'h33, 8'h44, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_op = ADD;
    bus.in_a = 8'h55;
    bus.in_b = 8'h66;
    h = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 16'(bus.in_ready), 16'd0);
      chk("bp_hold", 16'(bus.out_sum), 16'(h[11:4]));
      tick();
    end
    pop_check("bp_pop1");
    do_op(ADD, 8'h55, 8'h66, 1'b0);
    pop_check("bp_pop2");
    pop_check("bp_pop3");

    do_op(RSV, 8'h12, 8'h34, 1'b1);
    chk("rsv_no_push", 16'(bus.out_valid), 16'd0);

    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      if (exp_q.size() == 2) pop_check("rnd_pre");
      do_op(rop, 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)));
    end
    while (exp_q.size() != 0) pop_check("drain");

    do_op(ADD, 8'h01, 8'h01, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_op = ADD;
    bus.in_a = 8'h40;
    bus.in_b = 8'h40;
    chk("mid_ready", 16'(bus.in_ready), 16'd1);
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 16'(bus.out_valid), 16'd0);
    chk("mid_out_sum", 16'(bus.out_sum), 16'd0);
    chk("mid_out_flags", 16'(bus.out_flags), 16'd0);
    chk("mid_flags", 16'(flags), 16'd0);
    chk("mid_err", 16'(err), 16'd0);
    chk("mid_add", {add_a, add_b}, 16'd0);
    mflags = 4'h0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_out_valid", 16'(bus.out_valid), 16'd0);
    chk("post_ready", 16'(bus.in_ready), 16'd1);
    do_op(ADC, 8'h02, 8'h03, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
